// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM stage and data memory; loads bypass unless they overlap a buffered store.
// Load latency 1 cycle; req_ready drops for overlapping loads and for any load or store while the buffer is full.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [1:0]             req_type,
  input  logic                   req_unsigned,
  output logic                   resp_valid,
  output logic [31:0]            resp_data,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_write_data,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [1:0]             load_store_type,
  output logic                   load_unsigned,
  input  logic [31:0]            mem_read_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] e_addr [DEPTH];
  logic [31:0]       e_data [DEPTH];
  logic [1:0]        e_type [DEPTH];
  logic [DEPTH-1:0]  e_vld;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     cnt;

  logic hazard, full, illegal, ld_grant, drain, enq;
  logic [ADDR_W-1:0] ld_hi;

  function automatic logic [ADDR_W-1:0] span_hi(input logic [ADDR_W-1:0] lo, input logic [1:0] typ);
    case (typ)
      2'd0:    span_hi = lo;
      2'd1:    span_hi = lo + ADDR_W'(1);
      default: span_hi = lo + ADDR_W'(3);
    endcase
  endfunction

  assign ld_hi = span_hi(req_addr, req_type);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_vld[i] && (req_addr <= span_hi(e_addr[i], e_type[i])) && (e_addr[i] <= ld_hi))
        hazard = 1'b1;
    end
  end

  assign full    = (cnt == CW'(DEPTH));
  assign illegal = (req_type == 2'd3);

  // Nothing touches memory or is accepted while reset is held, so discarded stores never commit.
  assign req_ready = !rst && (illegal || (req_write ? !full : (!hazard && !full)));
  assign ld_grant  = !rst && req_valid && !req_write && !illegal && !hazard && !full;
  assign drain     = !rst && !ld_grant && (cnt != '0);
  assign enq       = !rst && req_valid && req_write && !illegal && !full;

  always_comb begin
    mem_addr        = '0;
    mem_write_data  = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    load_store_type = 2'd0;
    load_unsigned   = 1'b0;
    if (ld_grant) begin
      mem_read        = 1'b1;
      mem_addr        = req_addr;
      load_store_type = req_type;
      load_unsigned   = req_unsigned;
    end else if (drain) begin
      mem_write       = 1'b1;
      mem_addr        = e_addr[rd_ptr];
      mem_write_data  = e_data[rd_ptr];
      load_store_type = e_type[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_type[i] <= '0;
      end
      e_vld      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= ld_grant;
      if (ld_grant)
        resp_data <= mem_read_data;
      if (drain) begin
        e_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (enq) begin
        e_addr[wr_ptr] <= req_addr;
        e_data[wr_ptr] <= req_wdata;
        e_type[wr_ptr] <= req_type;
        e_vld[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({enq, drain})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: byte-array memory device, queue-based reference model, directed table and random traffic.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_type;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, load_unsigned, empty;
  logic [1:0]  load_store_type;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .load_store_type(load_store_type), .load_unsigned(load_unsigned), .mem_read_data(mem_read_data),
    .empty(empty), .count(count)
  );

  // dev_mem is the memory the DUT talks to; ref_mem is what memory should hold per the model.
  logic [7:0] dev_mem [256];
  logic [7:0] ref_mem [256];
  logic [31:0] wr_log [$];

  typedef struct { logic [31:0] a; logic [31:0] d; logic [1:0] t; } st_t;
  st_t q [$];
  logic        exp_rv;
  logic [31:0] exp_rd;

  int checks = 0;
  int failures = 0;

  logic        o_rdy, o_mw, o_mr, o_rv;
  logic [31:0] o_ma, o_wd, o_rd;
  logic [1:0]  o_t;
  logic [2:0]  o_cnt;

  function automatic int nbytes(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] t, input logic u);
    case (t)
      2'd0:    return u ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return u ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb
    mem_read_data = ext({dev_mem[8'(mem_addr + 3)], dev_mem[8'(mem_addr + 2)],
                         dev_mem[8'(mem_addr + 1)], dev_mem[8'(mem_addr)]},
                        load_store_type, load_unsigned);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, predict and compare at negedge, then let memory commit at posedge.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] t, input logic u, input logic r);
    logic e_rdy, e_mr, e_mw, e_u, hz, full, nrv;
    logic [31:0] e_ma, e_wd, nrd;
    logic [1:0] e_t;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    req_type = t; req_unsigned = u; rst = r;
    @(negedge clk);
    chk("count", 32'(count), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (exp_rv) chk("resp_data", resp_data, exp_rd);
    e_rdy = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_u = 1'b0; e_ma = '0; e_wd = '0; e_t = '0;
    nrv = 1'b0; nrd = '0;
    if (r) begin
      q.delete();
    end else begin
      hz = 1'b0;
      foreach (q[i])
        if (a <= q[i].a + 32'(nbytes(q[i].t)) - 1 && q[i].a <= a + 32'(nbytes(t)) - 1) hz = 1'b1;
      full = (q.size() == DEPTH);
      e_rdy = (t == 2'd3) || (w ? !full : (!hz && !full));
      if (v && !w && t != 2'd3 && e_rdy) begin
        e_mr = 1'b1; e_ma = a; e_t = t; e_u = u; nrv = 1'b1;
        nrd = ext({ref_mem[8'(a + 3)], ref_mem[8'(a + 2)], ref_mem[8'(a + 1)], ref_mem[8'(a)]}, t, u);
      end else if (q.size() > 0) begin
        e_mw = 1'b1; e_ma = q[0].a; e_wd = q[0].d; e_t = q[0].t;
        for (int k = 0; k < nbytes(e_t); k++) ref_mem[8'(e_ma + 32'(k))] = e_wd[8*k +: 8];
        void'(q.pop_front());
      end
      if (v && w && t != 2'd3 && e_rdy) q.push_back('{a, d, t});
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
    end
    chk("mem_read", 32'(mem_read), 32'(e_mr));
    chk("mem_write", 32'(mem_write), 32'(e_mw));
    chk("mem_addr", mem_addr, e_ma);
    chk("load_store_type", 32'(load_store_type), 32'(e_t));
    if (!e_mr) chk("mem_write_data", mem_write_data, e_wd);
    if (!e_mw) chk("load_unsigned", 32'(load_unsigned), 32'(e_u));
    o_rdy = req_ready; o_mw = mem_write; o_mr = mem_read; o_ma = mem_addr; o_wd = mem_write_data;
    o_t = load_store_type; o_cnt = count; o_rv = resp_valid; o_rd = resp_data;
    exp_rv = nrv;
    if (nrv) exp_rd = nrd;
    @(posedge clk);
    if (o_mw) begin
      for (int k = 0; k < nbytes(o_t); k++) dev_mem[8'(o_ma + 32'(k))] = o_wd[8*k +: 8];
      wr_log.push_back(o_ma);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'hF0, 32'h0, 2'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic v, w; logic [31:0] a, d; logic [1:0] t; logic u;
    logic rdy, mw, mr; logic [31:0] ma; logic [2:0] cnt; logic rv; logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic v, w, input logic [31:0] a, d, input logic [1:0] t, input logic u,
                              input logic rdy, mw, mr, input logic [31:0] ma, input logic [2:0] cnt,
                              input logic rv, input logic [31:0] rd);
    vec_t x;
    x.v = v; x.w = w; x.a = a; x.d = d; x.t = t; x.u = u;
    x.rdy = rdy; x.mw = mw; x.mr = mr; x.ma = ma; x.cnt = cnt; x.rv = rv; x.rd = rd;
    return x;
  endfunction

  vec_t tbl [12];

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'hF0; req_wdata = '0;
    req_type = 2'd0; req_unsigned = 1'b0; rst = 1'b1;
    q.delete(); exp_rv = 1'b0; exp_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    @(posedge clk); #1;

    //            v     w     addr   wdata          t     u     rdy   mw    mr    ma      cnt rv    rd
    tbl[0]  = mk(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 32'hF0, 32'h0,        2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1, 1'b0, 32'h0);
    tbl[2]  = mk(1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 0, 1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 32'hF0, 32'h0,        2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b1, 32'hDEADBEEF);
    tbl[4]  = mk(1'b1, 1'b1, 32'h21, 32'h80,       2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h0);
    tbl[5]  = mk(1'b1, 1'b0, 32'h20, 32'h0,        2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h21, 1, 1'b0, 32'h0);
    tbl[6]  = mk(1'b1, 1'b0, 32'h20, 32'h0,        2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 0, 1'b0, 32'h0);
    tbl[7]  = mk(1'b1, 1'b0, 32'h20, 32'h0,        2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 0, 1'b1, 32'hFFFF8085);
    tbl[8]  = mk(1'b0, 1'b0, 32'hF0, 32'h0,        2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b1, 32'h00008085);
    tbl[9]  = mk(1'b1, 1'b1, 32'h30, 32'h12345678, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h0);
    tbl[10] = mk(1'b1, 1'b0, 32'h30, 32'h0,        2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h0);
    tbl[11] = mk(1'b0, 1'b0, 32'hF0, 32'h0,        2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].t, tbl[i].u, 1'b0);
      chk($sformatf("tbl%0d_ready", i), 32'(o_rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_mem_write", i), 32'(o_mw), 32'(tbl[i].mw));
      chk($sformatf("tbl%0d_mem_read", i), 32'(o_mr), 32'(tbl[i].mr));
      chk($sformatf("tbl%0d_mem_addr", i), o_ma, tbl[i].ma);
      chk($sformatf("tbl%0d_count", i), 32'(o_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_resp_valid", i), 32'(o_rv), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_resp_data", i), o_rd, tbl[i].rd);
    end

    // Stores drain in order while a non-overlapping load takes the port ahead of the pending drain.
    wr_log.delete();
    step(1'b1, 1'b1, 32'h00, 32'h01010101, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h04, 32'h02020202, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h40, 32'h0,        2'd2, 1'b0, 1'b0);
    chk("seq3_load_granted", 32'(o_mr), 32'd1);
    chk("seq3_load_no_drain", 32'(o_mw), 32'd0);
    chk("seq3_count_at_load", 32'(o_cnt), 32'd1);
    step(1'b1, 1'b1, 32'h08, 32'h03030303, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0C, 32'h04040404, 2'd2, 1'b0, 1'b0);
    idle();
    idle();
    chk("seq3_write_count", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      chk("seq3_order0", wr_log[0], 32'h00);
      chk("seq3_order1", wr_log[1], 32'h04);
      chk("seq3_order2", wr_log[2], 32'h08);
      chk("seq3_order3", wr_log[3], 32'h0C);
    end

    // Word store straddling a word boundary, then overlapping loads.
    step(1'b1, 1'b1, 32'h0E, 32'h11223344, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("seq4_stall", 32'(o_rdy), 32'd0);
    chk("seq4_drain_addr", o_ma, 32'h0E);
    step(1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("seq4_grant", 32'(o_mr), 32'd1);
    step(1'b1, 1'b0, 32'h0E, 32'h0, 2'd2, 1'b0, 1'b0);
    chk("seq4_byte", o_rd, 32'h00000011);
    idle();
    chk("seq4_word", o_rd, 32'h11223344);

    // Enqueue alongside drain, then reset with a store pending and a load presented.
    step(1'b1, 1'b1, 32'h30, 32'hAAAA5555, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h34, 32'h5555AAAA, 2'd2, 1'b0, 1'b0);
    chk("seq5_count_hold", 32'(o_cnt), 32'd1);
    chk("seq5_drain_head", o_ma, 32'h30);
    step(1'b1, 1'b1, 32'h38, 32'h77777777, 2'd2, 1'b0, 1'b0);
    chk("seq5_count_hold2", 32'(o_cnt), 32'd1);
    step(1'b1, 1'b0, 32'h38, 32'h0, 2'd2, 1'b0, 1'b1);
    chk("seq5_no_write_in_reset", 32'(o_mw), 32'd0);
    idle();
    chk("seq5_count_cleared", 32'(o_cnt), 32'd0);
    chk("seq5_no_resp", 32'(o_rv), 32'd0);
    chk("seq5_no_write_after", 32'(o_mw), 32'd0);
    step(1'b1, 1'b0, 32'h38, 32'h0, 2'd2, 1'b0, 1'b0);
    idle();
    chk("seq5_store_discarded", o_rd, 32'h9E9F9C9D);

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic v, w, u, r;
      logic [1:0] t;
      v = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      t = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      u = $urandom_range(0, 1) == 1;
      r = ($urandom_range(0, 199) == 0);
      step(v, w, 32'($urandom_range(0, 63)), $urandom, t, u, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
